led_bank_arbiter: RTL and testbench
===================================

# led_bank_arbiter

Fabric-side controller that owns the board's eight LED outputs and shares them between two requesters: a built-in fabric pattern sequencer (default owner) and the MSS, which drives its GPIO outputs and requests ownership over a level handshake. It sits between the `test_system_sb` GPIO outputs and the LED pins. It provides glitch-free handover, with one blanking cycle in each direction, and a step-timed pattern generator clocked from the fabric CCC.

## Interface
- `TICK_DIV`, default 50_000_000: `FAB_CCC_GL0` cycles per pattern step. Legal values are ≥ 2. The tick counter width is clog2(`TICK_DIV`).
- `FAB_CCC_GL0` in 1: single clock; all state is on its rising edge.
- `POWER_ON_RESET_N` in 1: reset, asynchronous and active-low.
- `MSS_READY` in 1: MSS ready flag. It is fabric-synchronous and used directly.
- `MSS_REQ` in 1: MSS ownership request (level). It passes through a 2-flop synchronizer.
- `MSS_GPIO` in 8: LED values from the MSS ({GPIO_7_OUT..GPIO_5_OUT, GPIO_4_M2F..GPIO_0_M2F}).
- `PAT_MODE` in 2: fabric pattern select. 00 = off, 01 = walking one, 10 = binary count, 11 = blink.
- `MSS_GNT` out 1: registered; high exactly while state = MSS.
- `LED` out 8: registered LED drive.
- `STEP` out 1: one-cycle pulse on each pattern step.

## Operation
- FSM states: FAB, BLANK_M, MSS, BLANK_F. Reset state is FAB.
- FAB → BLANK_M when `req_s` & `MSS_READY`. `req_s` is the synchronized `MSS_REQ`.
- BLANK_M → MSS unconditionally after 1 cycle.
- MSS → BLANK_F when !`req_s` | !`MSS_READY`.
- BLANK_F → FAB unconditionally after 1 cycle.
- `LED` by state:
  - FAB: `LED` = `pat`.
  - BLANK_M / BLANK_F: `LED` = 0x00.
  - MSS: `LED` = `MSS_GPIO`, registered once, so it is one cycle behind the input.
- Tick counter:
  - Runs only in FAB, counting 0..`TICK_DIV`-1 and wrapping.
  - Held at 0 in every other state.
  - `STEP` = 1 for the cycle after the counter reaches `TICK_DIV`-1, i.e. registered on the wrap edge. `STEP` is never asserted outside FAB.
- Pattern register `pat`, advanced on each step:
  - Mode 00: constant 0x00.
  - Mode 01: initial 0x01, rotate left; 0x80 → 0x01.
  - Mode 10: initial 0x00, +1 modulo 256; 0xFF → 0x00.
  - Mode 11: initial 0x00, invert; alternates 0xFF / 0x00.
- Mode change: `PAT_MODE` is compared each cycle with the registered copy `mode_q`.
  - On a difference: `pat` is loaded with the initial value of the new mode, the tick counter clears, and `mode_q` updates, all on the same edge.
  - A mode change takes priority over a step on the same edge.
- Entry to FAB from BLANK_F: `pat` is reloaded with the initial value of the current mode and the tick counter clears.
- A `MSS_REQ` pulse shorter than 2 cycles may be missed; this is legal.
- A request that drops during BLANK_M still completes the MSS entry, then exits on the next evaluation.

## Timing
- Reset values: `LED` = 0x00, `MSS_GNT` = 0, `STEP` = 0, state = FAB, `pat` = 0x00, `mode_q` = 00, tick = 0, synchronizer flops = 0.
- A non-zero `PAT_MODE` at reset release is seen as a mode change on the first edge.
- Request path. With `MSS_REQ` rising before edge k:
  - `req_s` = 1 after edge k+1.
  - State = BLANK_M and `LED` = 0x00 after edge k+2.
  - State = MSS and `MSS_GNT` = 1 after edge k+3, with `LED` = `MSS_GPIO` sampled at edge k+3.
- MSS_GPIO latency: `LED` follows `MSS_GPIO` with 1-cycle latency while in MSS.
- Release path. With `MSS_REQ` falling before edge k:
  - `req_s` = 0 after edge k+1.
  - `MSS_GNT` = 0 and `LED` = 0x00 after edge k+2.
  - State = FAB with `LED` = initial pattern after edge k+3.
- `MSS_READY` deasserting in MSS: BLANK_F follows on the next edge, with no synchronizer delay.
- Step timing: in FAB with no disturbance, the first step occurs `TICK_DIV` cycles after FAB entry or mode change. Steps then repeat every `TICK_DIV` cycles.
- Asynchronous reset mid-operation, in any state: outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- Walking one: `TICK_DIV` = 4, `PAT_MODE` = 01 from reset. Required: `LED` sequence 0x01, 0x02, …, 0x80, 0x01, with each value held 4 cycles and one `STEP` pulse per transition.
- Binary count wrap: `TICK_DIV` = 2, mode 10, run 256 steps. Required: `LED` goes 0xFF → 0x00; the first post-reset value is 0x00.
- Handover to MSS: in FAB mode 11, raise `MSS_REQ` with `MSS_GPIO` = 0xA5. Required:
  - `LED` = 0x00 exactly one cycle.
  - `MSS_GNT` = 1 three edges after the request.
  - `LED` = 0xA5.
  - No `STEP` pulses while in MSS.
- Release and `MSS_READY` drop:
  - Drop `MSS_REQ`. Required: `MSS_GNT` = 0 at k+2, one blank cycle, then `LED` restarts at the initial pattern value (0x01 in mode 01).
  - Repeat, but drop `MSS_READY` instead. Required: BLANK_F on the next edge.
- Mode change: change mode 01 → 10 on the same edge a step is due. Required: `LED` = 0x00 (reload wins), tick cleared, next step `TICK_DIV` cycles later.
- Reset mid-MSS: assert `POWER_ON_RESET_N` = 0 asynchronously while `MSS_GNT` = 1. Required: `MSS_GNT` = 0 and `LED` = 0x00 immediately; after release, state is FAB and the `MSS_REQ` sync restarts from 0.

Source files
------------

// File: rtl/led_bank_arbiter.sv
// Purpose: shares the eight board LEDs between a fabric pattern sequencer and the MSS GPIO,
//          with one blanking cycle on each handover and a step-timed pattern generator.
// Latency: LED/MSS_GNT/STEP registered; MSS_GPIO -> LED 1 cycle; MSS_REQ -> MSS_GNT 3 edges.
// Backpressure: none; the MSS requests by level and holds MSS_REQ until MSS_GNT, short pulses may drop.
//
// Ports:
//   FAB_CCC_GL0       fabric clock, all state on its rising edge
//   POWER_ON_RESET_N  asynchronous active-low reset
//   MSS_READY         MSS ready flag, already fabric-synchronous
//   MSS_REQ           MSS ownership request level (synchronized here)
//   MSS_GPIO[7:0]     LED values driven by the MSS
//   PAT_MODE[1:0]     00 off, 01 walking one, 10 binary count, 11 blink
//   MSS_GNT           high exactly while the MSS owns the LEDs
//   LED[7:0]          registered LED drive
//   STEP              one-cycle pulse per pattern step (fabric ownership only)

module led_bank_arbiter #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       FAB_CCC_GL0,
  input  logic       POWER_ON_RESET_N,
  input  logic       MSS_READY,
  input  logic       MSS_REQ,
  input  logic [7:0] MSS_GPIO,
  input  logic [1:0] PAT_MODE,
  output logic       MSS_GNT,
  output logic [7:0] LED,
  output logic       STEP
);

  localparam int unsigned TW = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_FAB     = 2'd0,
    ST_BLANK_M = 2'd1,
    ST_MSS     = 2'd2,
    ST_BLANK_F = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            req_meta;
  logic            req_s;
  logic [1:0]      mode_q;
  logic [7:0]      pat;
  logic [7:0]      pat_nxt;
  logic [TW-1:0]   tick;
  logic [TW-1:0]   tick_nxt;
  logic [7:0]      led_nxt;
  logic            mode_chg;
  logic            stay_fab;
  logic            tick_wrap;

  function automatic logic [7:0] pat_init(input logic [1:0] m);
    return (m == 2'b01) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] pat_adv(input logic [1:0] m, input logic [7:0] p);
    logic [7:0] r;
    case (m)
      2'b01:   r = {p[6:0], p[7]};
      2'b10:   r = p + 8'd1;
      2'b11:   r = ~p;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FAB:     if (req_s && MSS_READY)    state_nxt = ST_BLANK_M;
      ST_BLANK_M:                            state_nxt = ST_MSS;
      ST_MSS:     if (!req_s || !MSS_READY)  state_nxt = ST_BLANK_F;
      ST_BLANK_F:                            state_nxt = ST_FAB;
      default:                               state_nxt = ST_FAB;
    endcase
  end

  always_comb begin
    mode_chg  = (PAT_MODE != mode_q);
    // The counter only runs while the fabric keeps the LEDs across this edge; a step that
    // would land on the edge leaving FAB is dropped so STEP never shows up in a blank cycle.
    stay_fab  = (state == ST_FAB) && (state_nxt == ST_FAB);
    tick_wrap = stay_fab && !mode_chg && (tick == TICK_LAST);

    // Mode change beats FAB re-entry and both beat a step.
    pat_nxt = pat;
    if (mode_chg)
      pat_nxt = pat_init(PAT_MODE);
    else if (state == ST_BLANK_F)
      pat_nxt = pat_init(mode_q);
    else if (tick_wrap)
      pat_nxt = pat_adv(mode_q, pat);

    tick_nxt = '0;
    if (stay_fab && !mode_chg && (tick != TICK_LAST))
      tick_nxt = tick + TW'(1);

    // LED is registered from the next-state view so it changes on the same edge as the owner.
    case (state_nxt)
      ST_FAB:  led_nxt = pat_nxt;
      ST_MSS:  led_nxt = MSS_GPIO;
      default: led_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge FAB_CCC_GL0 or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
      state    <= ST_FAB;
      mode_q   <= 2'b00;
      pat      <= 8'h00;
      tick     <= '0;
      LED      <= 8'h00;
      MSS_GNT  <= 1'b0;
      STEP     <= 1'b0;
    end else begin
      req_meta <= MSS_REQ;
      req_s    <= req_meta;
      state    <= state_nxt;
      mode_q   <= PAT_MODE;
      pat      <= pat_nxt;
      tick     <= tick_nxt;
      LED      <= led_nxt;
      MSS_GNT  <= (state_nxt == ST_MSS);
      STEP     <= tick_wrap;
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
module tb_led_bank_arbiter;

  localparam int TICK_DIV = 4;
  localparam int PH_FAB = 0, PH_BM = 1, PH_MSS = 2, PH_BF = 3;

  typedef struct packed {
    logic [7:0] led;
    logic       gnt;
    logic       step;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mss_ready = 1'b1;
  logic       mss_req = 1'b0;
  logic [7:0] mss_gpio = 8'h00;
  logic [1:0] pat_mode = 2'b01;
  logic       mss_gnt;
  logic [7:0] led;
  logic       step;

  led_bank_arbiter #(.TICK_DIV(TICK_DIV)) dut (
    .FAB_CCC_GL0      (clk),
    .POWER_ON_RESET_N (rst_n),
    .MSS_READY        (mss_ready),
    .MSS_REQ          (mss_req),
    .MSS_GPIO         (mss_gpio),
    .PAT_MODE         (pat_mode),
    .MSS_GNT          (mss_gnt),
    .LED              (led),
    .STEP             (step)
  );

  always #5 clk = ~clk;

  exp_t expq[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  // Reference model: owner phase, request seen two edges late, and the pattern
  // derived from the number of whole steps since the last restart.
  int         m_ph;
  logic       m_r0, m_r1;
  logic [1:0] m_mq;
  int         m_steps;
  int         m_c;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
  endtask

  function automatic logic [7:0] patfn(input logic [1:0] m, input int s);
    case (m)
      2'd1:    return 8'(1 << (s % 8));
      2'd2:    return 8'(s % 256);
      2'd3:    return (s % 2 == 1) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = PH_FAB; m_r0 = 1'b0; m_r1 = 1'b0; m_mq = 2'b00; m_steps = 0; m_c = 0;
  endtask

  task automatic model_edge(output exp_t e);
    logic reqs;
    int   nph;
    reqs = m_r1;
    m_r1 = m_r0;
    m_r0 = mss_req;
    nph = m_ph;
    if (m_ph == PH_FAB && reqs && mss_ready) nph = PH_BM;
    else if (m_ph == PH_BM) nph = PH_MSS;
    else if (m_ph == PH_MSS && (!reqs || !mss_ready)) nph = PH_BF;
    else if (m_ph == PH_BF) nph = PH_FAB;
    e.step = 1'b0;
    if (pat_mode != m_mq || m_ph == PH_BF) begin
      m_mq = pat_mode; m_steps = 0; m_c = 0;
    end else if (m_ph == PH_FAB && nph == PH_FAB) begin
      m_c++;
      if (m_c == TICK_DIV) begin m_c = 0; m_steps++; e.step = 1'b1; end
    end else begin
      m_c = 0;
    end
    m_ph  = nph;
    e.gnt = (nph == PH_MSS);
    e.led = (nph == PH_FAB) ? patfn(m_mq, m_steps) : (nph == PH_MSS) ? mss_gpio : 8'h00;
  endtask

  task automatic drive(input logic req, input logic rdy, input logic [7:0] gpio, input logic [1:0] mode);
    exp_t e;
    mss_req = req; mss_ready = rdy; mss_gpio = gpio; pat_mode = mode;
    model_edge(e);
    @(posedge clk);
    expq.push_back(e);
    #1;
  endtask

  task automatic run(input int n, input logic req, input logic rdy, input logic [1:0] mode, input bit rnd_gpio, input logic [7:0] gpio);
    for (int i = 0; i < n; i++)
      drive(req, rdy, rnd_gpio ? 8'($urandom) : gpio, mode);
  endtask

  // Monitor: one expected entry per edge, compared half a cycle later.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("led", int'(led), int'(e.led));
      chk("gnt", int'(mss_gnt), int'(e.gnt));
      chk("step", int'(step), int'(e.step));
    end
  end

  initial begin
    logic       r_req, r_rdy;
    logic [1:0] r_mode;
    int         guard;
    model_reset();
    #12;
    chk("rst_led", int'(led), 0);
    chk("rst_gnt", int'(mss_gnt), 0);
    chk("rst_step", int'(step), 0);
    #10 rst_n = 1'b1;

    // Walking one from reset, then binary count through a full wrap.
    run(40, 1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    run(256 * TICK_DIV + 12, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00);

    // Handover from blink to MSS with a fixed pattern, then live GPIO.
    run(10, 1'b0, 1'b1, 2'b11, 1'b0, 8'h00);
    run(12, 1'b1, 1'b1, 2'b11, 1'b0, 8'hA5);
    run(8, 1'b1, 1'b1, 2'b11, 1'b1, 8'h00);

    // Release by request drop, restart in walking one.
    run(14, 1'b0, 1'b1, 2'b01, 1'b1, 8'h00);

    // Release by MSS_READY drop while the request stays high, then reacquire.
    run(8, 1'b1, 1'b1, 2'b01, 1'b1, 8'h00);
    run(6, 1'b1, 1'b0, 2'b01, 1'b1, 8'h00);
    run(8, 1'b1, 1'b1, 2'b01, 1'b1, 8'h00);

    // Back to fabric, then change mode on the very edge a step is due.
    run(6, 1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    guard = 0;
    while (!(m_ph == PH_FAB && m_c == TICK_DIV - 1) && guard < 50) begin
      drive(1'b0, 1'b1, 8'h00, 2'b01);
      guard++;
    end
    chk("step_due_found", int'(guard < 50), 1);
    run(3 * TICK_DIV + 2, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00);

    // Asynchronous reset while the MSS owns the LEDs.
    run(8, 1'b1, 1'b1, 2'b10, 1'b0, 8'h3C);
    chk("gnt_before_rst", int'(mss_gnt), 1);
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst_led", int'(led), 0);
    chk("async_rst_gnt", int'(mss_gnt), 0);
    chk("async_rst_step", int'(step), 0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    run(10, 1'b1, 1'b1, 2'b10, 1'b1, 8'h00);

    // Randomized traffic.
    r_req = 1'b0; r_rdy = 1'b1; r_mode = 2'b01;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)  r_req  = ~r_req;
      if ($urandom_range(15) == 0) r_rdy  = ~r_rdy;
      if ($urandom_range(63) == 0) r_mode = 2'($urandom);
      drive(r_req, r_rdy, 8'($urandom), r_mode);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
